// File: rtl/ehgu_fifo_wr_arb.sv
// Round-robin burst write arbiter sharing one ehgu_fifo write port.
// A credit counter mirrors free FIFO entries so the FIFO can never be overrun;
// read-side pops return credits.
module ehgu_fifo_wr_arb #(
  parameter  int NREQ   = 4,
  parameter  int DWIDTH = 8,
  parameter  int DEPTH  = 32,
  parameter  int BURST  = 4,
  localparam int CWIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   fifo_en,
  output logic                   fifo_din_valid,
  output logic [DWIDTH-1:0]      fifo_din,
  input  logic                   fifo_pop,
  output logic [NREQ-1:0]        gnt,
  output logic [CWIDTH-1:0]      credits,
  output logic                   err_overflow
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST) + 1;

  localparam logic [CWIDTH-1:0] FULL_CREDITS = CWIDTH'(DEPTH);
  localparam logic [BW-1:0]     LAST_BEAT    = BW'(BURST - 1);
  localparam logic [IW-1:0]     LAST_IDX     = IW'(NREQ - 1);
  localparam logic [NREQ-1:0]   ONE_HOT0     = NREQ'(1);
  localparam logic [IW:0]       NREQ_W       = (IW + 1)'(NREQ);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t            state_r;
  logic [IW-1:0]     gnt_idx_r;
  logic [IW-1:0]     rr_ptr_r;
  logic [BW-1:0]     beat_cnt_r;

  logic              credit_avail_s;
  logic              accept_s;
  logic              gnt_valid_s;
  logic              last_beat_s;
  logic              burst_end_s;
  logic              pick_found_s;
  logic [IW-1:0]     pick_idx_s;
  logic [DWIDTH-1:0] gnt_data_s;

  assign credit_avail_s = (credits != {CWIDTH{1'b0}});
  assign accept_s       = |(req_valid & req_ready);
  assign gnt_valid_s    = |(req_valid & gnt);
  assign last_beat_s    = (beat_cnt_r == LAST_BEAT);
  assign gnt_data_s     = req_data[gnt_idx_r * DWIDTH +: DWIDTH];

  // A burst ends on its last beat, when the owner drops valid, or when credits run dry.
  assign burst_end_s = (accept_s && last_beat_s) || !gnt_valid_s ||
                       (!credit_avail_s && !accept_s);

  // Only the granted requester may be accepted, and only while a FIFO slot is free.
  always_comb begin
    if (state_r == ST_BURST && credit_avail_s) begin
      req_ready = gnt;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Round-robin search: first valid requester strictly after rr_ptr, wrapping.
  always_comb begin
    logic [IW:0] cand_sum_s;
    logic [IW:0] cand_s;
    logic        hit_s;
    pick_found_s = 1'b0;
    pick_idx_s   = {IW{1'b0}};
    cand_sum_s   = {(IW + 1){1'b0}};
    cand_s       = {(IW + 1){1'b0}};
    hit_s        = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_sum_s   = {1'b0, rr_ptr_r} + (IW + 1)'(k);
      cand_s       = (cand_sum_s >= NREQ_W) ? (cand_sum_s - NREQ_W) : cand_sum_s;
      hit_s        = !pick_found_s && req_valid[cand_s[IW-1:0]];
      pick_idx_s   = hit_s ? cand_s[IW-1:0] : pick_idx_s;
      pick_found_s = pick_found_s | hit_s;
    end
  end

  // Arbitration FSM: grant selection, beat counting and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      gnt        <= {NREQ{1'b0}};
      gnt_idx_r  <= {IW{1'b0}};
      rr_ptr_r   <= LAST_IDX;
      beat_cnt_r <= {BW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (credit_avail_s && pick_found_s) begin
            state_r    <= ST_BURST;
            gnt        <= ONE_HOT0 << pick_idx_s;
            gnt_idx_r  <= pick_idx_s;
            beat_cnt_r <= {BW{1'b0}};
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (burst_end_s) begin
            state_r    <= ST_IDLE;
            gnt        <= {NREQ{1'b0}};
            rr_ptr_r   <= gnt_idx_r;
            beat_cnt_r <= {BW{1'b0}};
          end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + BW'(1);
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          gnt        <= {NREQ{1'b0}};
          beat_cnt_r <= {BW{1'b0}};
        end
      endcase
    end
  end

  // Write-side datapath: register the accepted word and strobe it into the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_en        <= 1'b0;
      fifo_din_valid <= 1'b0;
      fifo_din       <= {DWIDTH{1'b0}};
    end else begin
      fifo_en        <= 1'b1;
      fifo_din_valid <= accept_s;
      if (accept_s) begin
        fifo_din <= gnt_data_s;
      end else begin
        fifo_din <= fifo_din;
      end
    end
  end

  // Credit tracking: accepts consume, pops return; a pop on an empty FIFO is flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits      <= FULL_CREDITS;
      err_overflow <= 1'b0;
    end else begin
      case ({accept_s, fifo_pop})
        2'b10: credits <= credits - CWIDTH'(1);
        2'b01: begin
          if (credits == FULL_CREDITS) begin
            credits <= credits;
          end else begin
            credits <= credits + CWIDTH'(1);
          end
        end
        default: credits <= credits;
      endcase
      if (fifo_pop && credits == FULL_CREDITS) begin
        err_overflow <= 1'b1;
      end else begin
        err_overflow <= err_overflow;
      end
    end
  end

endmodule

// File: tb/tb_ehgu_fifo_wr_arb.sv
// Self-checking bench for ehgu_fifo_wr_arb: directed scenarios plus a random
// phase, all compared every cycle against a behavioural arbiter model.
module tb_ehgu_fifo_wr_arb;

  localparam int NREQ   = 4;
  localparam int DWIDTH = 8;
  localparam int DEPTH  = 32;
  localparam int BURST  = 4;
  localparam int CWIDTH = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   fifo_en;
  logic                   fifo_din_valid;
  logic [DWIDTH-1:0]      fifo_din;
  logic                   fifo_pop;
  logic [NREQ-1:0]        gnt;
  logic [CWIDTH-1:0]      credits;
  logic                   err_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // behavioural model state
  bit m_busy;
  int m_g;
  int m_beats;
  int m_ptr;
  int m_cred;
  bit m_err;
  bit m_dv;
  bit m_en;
  int m_din;

  // observation logs
  int              acc_cnt [NREQ];
  logic [NREQ-1:0] last_acc;
  logic [NREQ-1:0] prev_gnt;
  int              gnt_log[$];
  int              word_log[$];

  always #5 clk = ~clk;

  ehgu_fifo_wr_arb #(
    .NREQ(NREQ), .DWIDTH(DWIDTH), .DEPTH(DEPTH), .BURST(BURST)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_en(fifo_en), .fifo_din_valid(fifo_din_valid),
    .fifo_din(fifo_din), .fifo_pop(fifo_pop), .gnt(gnt), .credits(credits),
    .err_overflow(err_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lane(input int i);
    return int'(req_data[i*DWIDTH +: DWIDTH]);
  endfunction

  task automatic set_lane(input int i, input logic [DWIDTH-1:0] v);
    req_data[i*DWIDTH +: DWIDTH] = v;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_g = 0; m_beats = 0; m_ptr = NREQ - 1; m_cred = DEPTH;
    m_err = 1'b0; m_dv = 1'b0; m_en = 1'b0; m_din = 0;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
    gnt_log.delete();
    word_log.delete();
    prev_gnt = '0;
  endtask

  // One clock cycle: inputs were driven at the negedge; check, advance model, clock.
  task automatic step();
    int exp_gnt;
    int exp_rdy;
    int first;
    int idx;
    int old_cred;
    bit acc;
    #1;
    exp_gnt = m_busy ? (1 << m_g) : 0;
    exp_rdy = (m_busy && m_cred != 0) ? exp_gnt : 0;
    if (chk_on) begin
      chk("gnt", gnt, exp_gnt);
      chk("req_ready", req_ready, exp_rdy);
      chk("credits", credits, m_cred);
      chk("din_valid", fifo_din_valid, m_dv);
      chk("din", fifo_din, m_din);
      chk("err_overflow", err_overflow, m_err);
      chk("fifo_en", fifo_en, m_en);
      last_acc = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) if (last_acc[i]) acc_cnt[i]++;
      if (gnt != '0 && gnt != prev_gnt)
        for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
      prev_gnt = gnt;
      if (fifo_din_valid) word_log.push_back(int'(fifo_din));
    end else begin
      last_acc = '0;
    end
    acc      = m_busy && (m_cred != 0) && req_valid[m_g];
    old_cred = m_cred;
    if (rst) begin
      model_reset();
    end else begin
      m_en = 1'b1;
      m_dv = acc;
      if (acc) m_din = lane(m_g);
      if (fifo_pop && old_cred == DEPTH) m_err = 1'b1;
      if (acc && !fifo_pop) m_cred = m_cred - 1;
      else if (fifo_pop && !acc && old_cred < DEPTH) m_cred = m_cred + 1;
      if (!m_busy) begin
        first = -1;
        if (old_cred > 0) begin
          for (int k = 1; k <= NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (first < 0 && req_valid[idx]) first = idx;
          end
        end
        if (first >= 0) begin
          m_busy = 1'b1; m_g = first; m_beats = 0;
        end
      end else if (acc) begin
        m_beats++;
        if (m_beats == BURST) begin
          m_busy = 1'b0; m_ptr = m_g;
        end
      end else begin
        m_busy = 1'b0; m_ptr = m_g;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; fifo_pop = 1'b0;
    step();
    chk_on = 1'b1;
    step();
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    logic [DWIDTH-1:0] d0;
    bit reached;
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_pop = 1'b0;
    model_reset();
    clear_logs();
    @(negedge clk);

    // 1: reset values, FIFO enable rises after reset
    do_reset();
    chk("t1_credits", credits, 32);
    chk("t1_gnt", gnt, 0);
    chk("t1_din_valid", fifo_din_valid, 0);
    chk("t1_err", err_overflow, 0);
    step();
    chk("t1_fifo_en", fifo_en, 1);

    // 2: req0 alone, data 0x03, 0x06, ...
    do_reset();
    d0 = 8'h03;
    set_lane(0, d0);
    req_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step();
      if (last_acc[0]) begin
        d0 = d0 + 8'h03;
        set_lane(0, d0);
      end
    end
    chk("t2_beats", acc_cnt[0], 8);
    chk("t2_credits", credits, 24);
    chk("t2_word0", (word_log.size() > 0) ? word_log[0] : -1, 32'h03);
    chk("t2_word3", (word_log.size() > 3) ? word_log[3] : -1, 32'h0C);
    chk("t2_word4", (word_log.size() > 4) ? word_log[4] : -1, 32'h0F);

    // 3: all requesters valid, pops keep the FIFO draining
    do_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, DWIDTH'($urandom));
    req_valid = 4'b1111;
    for (int c = 0; c < 60; c++) begin
      fifo_pop = (m_cred < DEPTH);
      step();
      for (int i = 0; i < NREQ; i++) if (last_acc[i]) set_lane(i, DWIDTH'($urandom));
    end
    fifo_pop = 1'b0;
    for (int i = 0; i < NREQ; i++) chk("t3_beats", acc_cnt[i], 12);
    chk("t3_ngrants", gnt_log.size(), 12);
    for (int k = 0; k < 12; k++)
      chk("t3_order", (gnt_log.size() > k) ? gnt_log[k] : -1, k % NREQ);

    // 4: no pops, req0 streams until credits are exhausted
    do_reset();
    d0 = 8'h00;
    set_lane(0, d0);
    req_valid = 4'b0001;
    for (int c = 0; c < 60; c++) begin
      step();
      if (last_acc[0]) begin
        d0 = d0 + 8'h01;
        set_lane(0, d0);
      end
    end
    chk("t4_accepts", acc_cnt[0], 32);
    chk("t4_credits", credits, 0);
    chk("t4_ready", req_ready, 0);
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    chk("t4_credit_back", credits, 1);
    for (int c = 0; c < 10; c++) begin
      step();
      if (last_acc[0]) begin
        d0 = d0 + 8'h01;
        set_lane(0, d0);
      end
    end
    chk("t4_one_more", acc_cnt[0], 33);
    chk("t4_credits_end", credits, 0);

    // 5: accept and pop in the same cycle at credits=10
    do_reset();
    set_lane(0, 8'h5A);
    req_valid = 4'b0001;
    reached = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!reached) begin
        if (m_busy && m_cred == 10) reached = 1'b1;
        else step();
      end
    end
    chk("t5_pre_credits", credits, 10);
    chk("t5_pre_ready", req_ready[0], 1);
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    chk("t5_accepted", last_acc[0], 1);
    chk("t5_credits", credits, 10);

    // 6: reset in burst beat 2, then a pop on an empty FIFO
    do_reset();
    set_lane(0, 8'hC3);
    req_valid = 4'b0001;
    step();
    step();
    step();
    chk("t6_in_burst", gnt, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = '0;
    chk("t6_gnt", gnt, 0);
    chk("t6_credits", credits, 32);
    chk("t6_din_valid", fifo_din_valid, 0);
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    chk("t6_err", err_overflow, 1);
    step();
    step();
    chk("t6_err_sticky", err_overflow, 1);
    chk("t6_credits_hold", credits, 32);

    // random phase: slow drain first, then fast drain
    do_reset();
    for (int c = 0; c < 400; c++) begin
      fifo_pop = (m_cred < DEPTH) && ($urandom_range(0, 3) < ((c < 200) ? 1 : 3));
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (last_acc[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          set_lane(i, DWIDTH'($urandom));
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    fifo_pop  = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
